alu_16_bit: RTL and testbench
=============================

Name: alu_16_bit

Overview:
- 16-bit registered integer ALU for the datapath execute stage of the 16-bit MIPS-style CPU.
- Covers add, sub, and, or, slt, sll, srl and a bne-style compare.
- Operands and opcode are sampled on the rising clock edge. Result and zero flag are registered outputs, valid one cycle later.
- Opcodes are driven by the ALU control unit; zero_bit feeds branch logic.

Parameters:
- WIDTH, 16, operand/result width in bits. Shift amount uses the low clog2(WIDTH) bits of b (4 bits at default).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; 0 holds the outputs
- a  input  WIDTH  operand A (rs / shift source)
- b  input  WIDTH  operand B (rt / immediate / shift amount)
- alu_op  input  4  operation select
- res  output  WIDTH  registered result
- zero_bit  output  1  registered branch/zero flag

Behaviour:
- Reset: rst_n low immediately (asynchronously) forces res=0 and zero_bit=1. Outputs stay at these values while rst_n is low. Release is synchronous to the next clk edge.
- Latency: when en=1 at a rising edge, res and zero_bit take the function of the a/b/alu_op sampled at that edge. This is 1-cycle latency with no internal pipeline. When en=0, both outputs hold.
- Opcodes, with alu_op[3]=0:
  - 000 add: a+b mod 2^WIDTH; carry discarded. Used for add, addi, lw, sw.
  - 001 and: a&b.
  - 010 or: a|b.
  - 011 slt: 1 if signed(a) < signed(b), else 0, zero-extended to WIDTH.
  - 100 sub: a-b mod 2^WIDTH. Used for sub and beq.
  - 101 sll: a << b[3:0], zero fill.
  - 110 srl: a >> b[3:0], logical, zero fill.
  - 111 bne: a-b mod 2^WIDTH.
- b[WIDTH-1:4] is ignored for shifts, so a shift amount of 16 or more wraps to b[3:0].
- zero_bit:
  - For opcodes 0000-0110: zero_bit = (next res == 0).
  - For 0111: zero_bit = (next res != 0), i.e. 1 when a != b, giving the branch-taken condition for bne.
- alu_op[3]=1 without the optional feature: res=0, zero_bit=1.
- No overflow detection and no exceptions. Signed overflow in add/sub wraps silently.
- Combinational inputs may change at any time; only values present at the sampling edge matter.

Optional Feature:
- Macro ALU_EXT_OPS_EN.
- When defined, alu_op[3]=1 selects:
  - 1000 xor: a^b
  - 1001 nor: ~(a|b)
  - 1010 sra: arithmetic shift right by b[3:0]
  - 1011 sltu: unsigned a<b → 1 else 0
  - 1100 lui: b << 8
  - 1101-1111 reserved: res=0
- zero_bit = (res==0) for all of these.
- When not defined, every alu_op[3]=1 code gives res=0, zero_bit=1.

Test Plan:
- Reset: assert rst_n=0 mid-operation with res=0x1E1E → res=0 and zero_bit=1 immediately, without a clock edge. Release, apply add 0x0001+0x0001 → res=0x0002 one edge later.
- a=b=0x0F0F, en=1, sweep alu_op 000..111, one per cycle. Expected after each edge:
  - add: res 0x1E1E, z0
  - and: 0x0F0F, z0
  - or: 0x0F0F, z0
  - slt: 0x0000, z1
  - sub: 0x0000, z1
  - sll: 0x8000, z0
  - srl: 0x0000, z1
  - bne: 0x0000, z0
- Logic: a=0xF0F0, b=0x0F0F → and: res 0x0000, z1; or: res 0xFFFF, z0.
- Signed compare: a=0xE000, b=0xFFFF, slt → res 0x0001, z0. Swap operands → res 0x0000, z1. Also a=0x7FFF, b=0x8000 → res 0x0000.
- Wrap/enable:
  - add 0xFFFF+0x0001 → res 0x0000, z1.
  - bne with a=5, b=3 → res 0x0002, z1.
  - Then drop en=0 and change inputs → outputs hold 0x0002/1 for 3 cycles.
- alu_op=1000 without ALU_EXT_OPS_EN → res 0, z1. With the macro and a=0xF0F0, b=0x0F0F → res 0xFFFF, z0.

Source files
------------

// File: rtl/alu_16_bit_if.sv
// alu_16_bit_if: operand/result bus for the execute-stage ALU.
//   master (ALU control / testbench) drives en, a, b, alu_op and reads
//   res, zero_bit; slave (alu_16_bit) does the reverse.
//   en       - capture enable; 0 holds the ALU outputs
//   a, b     - operands (b low bits double as the shift amount)
//   alu_op   - 4-bit operation select
//   res      - registered result
//   zero_bit - registered branch/zero flag
interface alu_16_bit_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] res;
  logic             zero_bit;

  modport master (output en, a, b, alu_op, input res, zero_bit);
  modport slave  (input en, a, b, alu_op, output res, zero_bit);
endinterface

// File: rtl/alu_16_bit.sv
// alu_16_bit: registered integer ALU for the execute stage of a 16-bit
// MIPS-style datapath. Operands and opcode are sampled on the rising edge
// when en=1; res and zero_bit are valid one cycle later and hold when en=0.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (res=0, zero_bit=1)
//   bus   - alu_16_bit_if.slave (en, a, b, alu_op in; res, zero_bit out)
// Optional feature macro: ALU_EXT_OPS_EN enables the alu_op[3]=1 codes
// (xor, nor, sra, sltu, lui). Without it every alu_op[3]=1 code gives
// res=0, zero_bit=1.
module alu_16_bit #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_16_bit_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] res_d, res_q;
  logic             zero_d, zero_q;
  logic [SHW-1:0]   shamt;
  logic             slt_bit;
`ifdef ALU_EXT_OPS_EN
  logic signed [WIDTH-1:0] sra_v;
`endif

  // Upper bits of b are ignored for shifts, so amounts >= WIDTH wrap.
  assign shamt   = bus.b[SHW-1:0];
  assign slt_bit = $signed(bus.a) < $signed(bus.b);
`ifdef ALU_EXT_OPS_EN
  assign sra_v   = $signed(bus.a) >>> shamt;
`endif

  always_comb begin
    res_d  = '0;
    zero_d = 1'b1;
    if (!bus.alu_op[3]) begin
      unique case (bus.alu_op[2:0])
        3'b000: res_d = bus.a + bus.b;
        3'b001: res_d = bus.a & bus.b;
        3'b010: res_d = bus.a | bus.b;
        3'b011: res_d = WIDTH'(slt_bit);
        3'b100: res_d = bus.a - bus.b;
        3'b101: res_d = bus.a << shamt;
        3'b110: res_d = bus.a >> shamt;
        default: res_d = bus.a - bus.b;
      endcase
      // bne inverts the flag so it reads directly as "branch taken".
      zero_d = (bus.alu_op[2:0] == 3'b111) ? (res_d != '0) : (res_d == '0);
    end else begin
`ifdef ALU_EXT_OPS_EN
      unique case (bus.alu_op[2:0])
        3'b000:  res_d = bus.a ^ bus.b;
        3'b001:  res_d = ~(bus.a | bus.b);
        3'b010:  res_d = sra_v;
        3'b011:  res_d = WIDTH'(bus.a < bus.b);
        3'b100:  res_d = bus.b << 8;
        default: res_d = '0;
      endcase
      zero_d = (res_d == '0);
`else
      res_d  = '0;
      zero_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b1;
    end else if (bus.en) begin
      res_q  <= res_d;
      zero_q <= zero_d;
    end
  end

  assign bus.res      = res_q;
  assign bus.zero_bit = zero_q;
endmodule

// File: tb/tb_alu_16_bit.sv
module tb_alu_16_bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_16_bit_if #(.WIDTH(16)) bus ();
  alu_16_bit #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] held_res = 16'h0000;
  logic        held_z   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference: slt via sign bits, bne flag via equality.
  task automatic ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic z);
    logic lt;
    lt = (a[15] & ~b[15]) | (~(a[15] ^ b[15]) & (a < b));
    r  = 16'h0000;
    case (op)
      4'd0: r = 16'((32'(a) + 32'(b)) & 32'hFFFF);
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = {15'd0, lt};
      4'd4: r = 16'((32'(a) + 32'h10000 - 32'(b)) & 32'hFFFF);
      4'd5: r = a << b[3:0];
      4'd6: r = a >> b[3:0];
      4'd7: r = 16'((32'(a) + 32'h10000 - 32'(b)) & 32'hFFFF);
      default: r = 16'h0000;
    endcase
    z = (op == 4'd7) ? (a != b) : (r == 16'h0000);
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the result
  // the DUT should show after the following rising edge.
  task automatic drive(input string tag, input logic en, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ez);
    exp_t e;
    @(negedge clk);
    bus.en = en; bus.alu_op = op; bus.a = a; bus.b = b;
    if (en) begin held_res = er; held_z = ez; end
    e.tag = tag; e.res = held_res; e.z = held_z;
    sb.push_back(e);
  endtask

  // Monitor: after every rising edge, pop and compare one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".res"}, 32'(bus.res), 32'(e.res));
        chk({e.tag, ".z"},   32'(bus.zero_bit), 32'(e.z));
      end
    end
  end

  task automatic drain();
    int budget;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk); #2; budget--;
    end
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb, er;
    logic [3:0]  op;
    logic        ez;
    bus.en = 1'b0; bus.a = '0; bus.b = '0; bus.alu_op = '0;
    #12;
    chk("rst.res", 32'(bus.res), 32'h0);
    chk("rst.z",   32'(bus.zero_bit), 32'h1);
    @(negedge clk); rst_n = 1'b1;

    // Sweep with a=b=0x0F0F.
    drive("add", 1, 4'd0, 16'h0F0F, 16'h0F0F, 16'h1E1E, 0);
    drive("and", 1, 4'd1, 16'h0F0F, 16'h0F0F, 16'h0F0F, 0);
    drive("or",  1, 4'd2, 16'h0F0F, 16'h0F0F, 16'h0F0F, 0);
    drive("slt", 1, 4'd3, 16'h0F0F, 16'h0F0F, 16'h0000, 1);
    drive("sub", 1, 4'd4, 16'h0F0F, 16'h0F0F, 16'h0000, 1);
    drive("sll", 1, 4'd5, 16'h0F0F, 16'h0F0F, 16'h8000, 0);
    drive("srl", 1, 4'd6, 16'h0F0F, 16'h0F0F, 16'h0000, 1);
    drive("bne", 1, 4'd7, 16'h0F0F, 16'h0F0F, 16'h0000, 0);
    // Logic patterns.
    drive("and2", 1, 4'd1, 16'hF0F0, 16'h0F0F, 16'h0000, 1);
    drive("or2",  1, 4'd2, 16'hF0F0, 16'h0F0F, 16'hFFFF, 0);
    // Signed compare.
    drive("slt_neg",  1, 4'd3, 16'hE000, 16'hFFFF, 16'h0001, 0);
    drive("slt_swap", 1, 4'd3, 16'hFFFF, 16'hE000, 16'h0000, 1);
    drive("slt_max",  1, 4'd3, 16'h7FFF, 16'h8000, 16'h0000, 1);
    // Wrap, bne, enable hold.
    drive("add_wrap", 1, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1);
    drive("sll_wrap", 1, 4'd5, 16'h0003, 16'h0011, 16'h0006, 0);
    drive("bne_ne",   1, 4'd7, 16'h0005, 16'h0003, 16'h0002, 1);
    drive("hold1", 0, 4'd0, 16'h1234, 16'h4321, 16'h0, 0);
    drive("hold2", 0, 4'd4, 16'hAAAA, 16'h5555, 16'h0, 0);
    drive("hold3", 0, 4'd2, 16'hFFFF, 16'h0000, 16'h0, 0);
    // Extended opcode space.
`ifdef ALU_EXT_OPS_EN
    drive("ext_xor", 1, 4'd8, 16'hF0F0, 16'h0F0F, 16'hFFFF, 0);
    drive("ext_sra", 1, 4'd10, 16'h8000, 16'h0004, 16'hF800, 0);
`else
    drive("ext_off", 1, 4'd8, 16'hF0F0, 16'h0F0F, 16'h0000, 1);
    drive("ext_off2", 1, 4'd15, 16'h1234, 16'h0001, 16'h0000, 1);
`endif
    // Random base opcodes against the reference.
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? ra : 16'($urandom);
      ref_alu(op, ra, rb, er, ez);
      drive($sformatf("rnd%0d_op%0d", i, op), 1, op, ra, rb, er, ez);
    end
    drain();

    // Asynchronous reset mid-operation.
    drive("pre_rst", 1, 4'd0, 16'h0F0F, 16'h0F0F, 16'h1E1E, 0);
    drain();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.res", 32'(bus.res), 32'h0);
    chk("async_rst.z",   32'(bus.zero_bit), 32'h1);
    @(posedge clk); #1;
    chk("rst_hold.res", 32'(bus.res), 32'h0);
    held_res = 16'h0; held_z = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    drive("post_rst_add", 1, 4'd0, 16'h0001, 16'h0001, 16'h0002, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
